instr_fetch: RTL

//  Instruction-fetch stage plus IF/ID pipeline register for the LEGv8 core. Holds the PC and fetches
//  32-bit words over a req/ack instruction-memory port. Presents the fetched word to the ID-stage

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/br_target_calc.sv | 30 +++
 rtl/instr_fetch.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared LEGv8 core definitions: instruction field positions, NOP opcode and the
// fetch-stage state encoding.
package cpu_pkg;

    localparam int INSTR_W   = 32;
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 21;
    localparam int OPC_W     = OPC_MSB - OPC_LSB + 1;
    localparam int IMM26_MSB = 25;
    localparam int IMM26_LSB = 0;
    localparam int IMM19_MSB = 23;
    localparam int IMM19_LSB = 5;

    localparam logic [OPC_W-1:0] NOP_OPCODE = 11'h000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/br_target_calc.sv
// Branch target adder: id_pc + (sign-extended imm26 or imm19) * 4, wrapping at ADDR_W.
// Kept separate so a later EX-stage branch resolver can reuse it.
module br_target_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0]  id_pc,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic               uncond_br,
    output logic [ADDR_W-1:0]  target
);

    logic [ADDR_W-1:0] offset;
    logic              unused_bits;

    // Opcode and register fields do not contribute to the target.
    assign unused_bits = &{1'b0, id_instr[31:26], id_instr[4:0]};

    always_comb begin
        offset = '0;
        if (uncond_br)
            offset = {{(ADDR_W-26){id_instr[IMM26_MSB]}}, id_instr[IMM26_MSB:IMM26_LSB]};
        else
            offset = {{(ADDR_W-19){id_instr[IMM19_MSB]}}, id_instr[IMM19_MSB:IMM19_LSB]};
    end

    assign target = id_pc + {offset[ADDR_W-3:0], 2'b00};

endmodule

// File: rtl/instr_fetch.sv
// LEGv8 instruction-fetch stage with IF/ID register, skid buffer and branch redirect.
// Define DELAY_SLOT_EN to deliver the branch_pc+4 word as a delay slot instead of killing it.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_taken,
    input  logic               uncond_br,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [OPC_W-1:0]   opCode,
    output logic [1:0]         dbg_state
);

    // imem handshake: imem_req rises with imem_addr and both hold until a cycle with
    // imem_ack=1, which carries imem_rdata and ends the request; ack without req is ignored.
    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic [INSTR_W-1:0] skid_q, skid_d;
    logic               req_en_q;
    logic [ADDR_W-1:0]  target;
    logic               ack, redirect;
`ifdef DELAY_SLOT_EN
    logic               pend_q, pend_d, pend_now;
    logic [ADDR_W-1:0]  pend_tgt_q, pend_tgt_d, next_pc;
    logic               id_slot_q, id_slot_d;
`else
    logic [ADDR_W-1:0]  kill_tgt_q, kill_tgt_d;
`endif

    br_target_calc #(.ADDR_W(ADDR_W)) u_br_target (
        .id_pc     (id_pc_q),
        .id_instr  (id_instr_q),
        .uncond_br (uncond_br),
        .target    (target)
    );

    assign imem_req  = req_en_q & (state_q != HOLD);
    assign imem_addr = pc_q;
    assign ack       = imem_ack & imem_req;
    assign redirect  = id_valid_q & br_taken & ~stall;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign opCode    = id_valid_q ? opcode_of(id_instr_q) : NOP_OPCODE;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        skid_d     = skid_q;
`ifdef DELAY_SLOT_EN
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        id_slot_d  = id_slot_q;
        pend_now   = pend_q | redirect;
        next_pc    = pend_now ? (redirect ? target : pend_tgt_q) : pc_q + ADDR_W'(4);
        if (redirect) begin
            pend_d     = 1'b1;
            pend_tgt_d = target;
        end
        case (state_q)
            FETCH: begin
                if (ack && !stall) begin
                    id_valid_d = 1'b1;
                    id_instr_d = imem_rdata;
                    id_pc_d    = pc_q;
                    id_slot_d  = pend_now;
                    pc_d       = next_pc;
                    pend_d     = 1'b0;
                end else if (ack) begin
                    skid_d  = imem_rdata;
                    state_d = HOLD;
                end else if (!stall) begin
                    id_valid_d = 1'b0;
                    id_slot_d  = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    id_valid_d = 1'b1;
                    id_instr_d = skid_q;
                    id_pc_d    = pc_q;
                    id_slot_d  = pend_now;
                    pc_d       = next_pc;
                    pend_d     = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
`else
        kill_tgt_d = kill_tgt_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    id_valid_d = 1'b0;
                    if (ack) begin
                        pc_d = target;
                    end else begin
                        kill_tgt_d = target;
                        state_d    = KILL;
                    end
                end else if (ack && !stall) begin
                    id_valid_d = 1'b1;
                    id_instr_d = imem_rdata;
                    id_pc_d    = pc_q;
                    pc_d       = pc_q + ADDR_W'(4);
                end else if (ack) begin
                    skid_d  = imem_rdata;
                    state_d = HOLD;
                end else if (!stall) begin
                    id_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    id_valid_d = 1'b0;
                    pc_d       = target;
                    state_d    = FETCH;
                end else if (!stall) begin
                    id_valid_d = 1'b1;
                    id_instr_d = skid_q;
                    id_pc_d    = pc_q;
                    pc_d       = pc_q + ADDR_W'(4);
                    state_d    = FETCH;
                end
            end
            KILL: begin
                // The wrong-path request must still complete before the address may change.
                if (ack) begin
                    pc_d    = kill_tgt_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            skid_q     <= '0;
            req_en_q   <= 1'b0;
`ifdef DELAY_SLOT_EN
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            id_slot_q  <= 1'b0;
`else
            kill_tgt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            skid_q     <= skid_d;
            req_en_q   <= 1'b1;
`ifdef DELAY_SLOT_EN
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            id_slot_q  <= id_slot_d;
`else
            kill_tgt_q <= kill_tgt_d;
`endif
        end
    end

    a_addr_stable: assert property (@(posedge clk) disable iff (reset)
        (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

`ifdef DELAY_SLOT_EN
    a_no_branch_in_slot: assert property (@(posedge clk) disable iff (reset)
        !(id_valid_q && id_slot_q && br_taken && !stall));
`endif

endmodule
